// File: rtl/pls_tx_sequencer_if.sv
// MAC-to-sequencer byte stream.
// Handshake: a byte transfers on a posedge where mac_valid and mac_ready
// are both high. mac_data and mac_last are only meaningful while
// mac_valid is high. mac_ready may be high with no byte offered.
interface pls_tx_sequencer_if;
   logic [7:0] mac_data;
   logic       mac_valid;
   logic       mac_last;
   logic       mac_abort;
   logic       mac_ready;

   modport master (output mac_data, output mac_valid, output mac_last,
                   output mac_abort, input mac_ready);
   modport slave  (input mac_data, input mac_valid, input mac_last,
                   input mac_abort, output mac_ready);
endinterface

// File: rtl/pls_tx_sequencer.sv
// Transmit PLS sequencer: serializes MAC bytes LSB-first onto one-hot
// PLS_DATA.request lines, adds half-duplex carrier extension, signals
// extend-error on abort/underrun and times the inter-frame gap.
// Every output is a flop loaded from the decoded next state, so the
// request lines are glitch-free and exactly one of them is high.
module pls_tx_sequencer #(
   parameter int SLOT_BITS = 4096,
   parameter int IPG_BITS  = 96,
   parameter int CNT_W     = 13
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pls_tx_sequencer_if.slave        mac,
   input  logic                     half_duplex,
   output logic                     pls_data_request_complete,
   output logic                     pls_data_request_extend,
   output logic                     pls_data_request_extenderror,
   output logic                     pls_data_request_zero,
   output logic                     pls_data_request_one,
   output logic                     busy,
   output logic [2:0]               dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_EXTEND = 3'd2,
      S_ERROR  = 3'd3,
      S_IPG    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);
   localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_BITS - 1);
   localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   state_t             state, nxt_state;
   logic [7:0]         sh, nxt_sh;
   logic [2:0]         bit_idx, nxt_idx;
   logic               last_q, nxt_last;
   logic               hd_q, nxt_hd;
   logic [CNT_W-1:0]   bit_cnt, nxt_bit_cnt;
   logic [CNT_W-1:0]   cyc_cnt, nxt_cyc_cnt;
   logic               accept;
   logic               nxt_ready, nxt_complete, nxt_extend, nxt_error;
   logic               nxt_zero, nxt_one, nxt_busy;

   assign accept    = mac.mac_valid & mac.mac_ready;
   assign dbg_state = state;

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                        <= S_IDLE;
         sh                           <= '0;
         bit_idx                      <= '0;
         last_q                       <= 1'b0;
         hd_q                         <= 1'b0;
         bit_cnt                      <= '0;
         cyc_cnt                      <= '0;
         mac.mac_ready                <= 1'b1;
         pls_data_request_complete    <= 1'b1;
         pls_data_request_extend      <= 1'b0;
         pls_data_request_extenderror <= 1'b0;
         pls_data_request_zero        <= 1'b0;
         pls_data_request_one         <= 1'b0;
         busy                         <= 1'b0;
      end else begin
         state                        <= nxt_state;
         sh                           <= nxt_sh;
         bit_idx                      <= nxt_idx;
         last_q                       <= nxt_last;
         hd_q                         <= nxt_hd;
         bit_cnt                      <= nxt_bit_cnt;
         cyc_cnt                      <= nxt_cyc_cnt;
         mac.mac_ready                <= nxt_ready;
         pls_data_request_complete    <= nxt_complete;
         pls_data_request_extend      <= nxt_extend;
         pls_data_request_extenderror <= nxt_error;
         pls_data_request_zero        <= nxt_zero;
         pls_data_request_one         <= nxt_one;
         busy                         <= nxt_busy;
      end
   end

   // Next-state, datapath update and decode of next-cycle outputs.
   always_comb begin
      nxt_state   = state;
      nxt_sh      = sh;
      nxt_idx     = bit_idx;
      nxt_last    = last_q;
      nxt_hd      = hd_q;
      nxt_bit_cnt = bit_cnt;
      nxt_cyc_cnt = cyc_cnt;

      case (state)
         S_IDLE: begin
            if (accept) begin
               nxt_sh      = mac.mac_data;
               nxt_last    = mac.mac_last;
               nxt_hd      = half_duplex;
               nxt_idx     = '0;
               nxt_bit_cnt = '0;
               nxt_state   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_cnt != SLOT_C) nxt_bit_cnt = bit_cnt + ONE_C;
            // Abort wins over both a new byte and an underrun.
            if (mac.mac_abort) begin
               nxt_state   = S_ERROR;
               nxt_cyc_cnt = '0;
            end else if (bit_idx == 3'd7) begin
               if (!last_q) begin
                  if (accept) begin
                     nxt_sh   = mac.mac_data;
                     nxt_last = mac.mac_last;
                     nxt_idx  = '0;
                  end else begin
                     nxt_state   = S_ERROR;
                     nxt_cyc_cnt = '0;
                  end
               end else if (hd_q && ((bit_cnt + ONE_C) < SLOT_C)) begin
                  nxt_state = S_EXTEND;
               end else begin
                  nxt_state   = S_IPG;
                  nxt_cyc_cnt = '0;
               end
            end else begin
               nxt_idx = bit_idx + 3'd1;
            end
         end
         S_EXTEND: begin
            nxt_bit_cnt = bit_cnt + ONE_C;
            if ((bit_cnt + ONE_C) >= SLOT_C) begin
               nxt_state   = S_IPG;
               nxt_cyc_cnt = '0;
            end
         end
         S_ERROR: begin
            if (cyc_cnt == ERR_LAST) begin
               nxt_state   = S_IPG;
               nxt_cyc_cnt = '0;
            end else begin
               nxt_cyc_cnt = cyc_cnt + ONE_C;
            end
         end
         S_IPG: begin
            if (cyc_cnt == IPG_LAST) nxt_state = S_IDLE;
            else                     nxt_cyc_cnt = cyc_cnt + ONE_C;
         end
         default: nxt_state = S_IDLE;
      endcase

      nxt_complete = (nxt_state == S_IDLE) || (nxt_state == S_IPG);
      nxt_extend   = (nxt_state == S_EXTEND);
      nxt_error    = (nxt_state == S_ERROR);
      nxt_one      = (nxt_state == S_DATA) &&  nxt_sh[nxt_idx];
      nxt_zero     = (nxt_state == S_DATA) && !nxt_sh[nxt_idx];
      nxt_ready    = (nxt_state == S_IDLE) ||
                     ((nxt_state == S_DATA) && (nxt_idx == 3'd7) && !nxt_last);
      nxt_busy     = (nxt_state != S_IDLE);
   end

endmodule

// File: tb/tb_pls_tx_sequencer.sv
// Bench for pls_tx_sequencer: directed scenarios plus randomized frames,
// each cycle compared against a frame-level reference sequence.
module tb_pls_tx_sequencer;
   localparam int SLOT_BITS = 64;
   localparam int IPG_BITS  = 16;
   localparam int CNT_W     = 13;
   localparam int W         = 7;

   // Observed vector: {busy, ready, one, zero, extenderror, extend, complete}
   localparam logic [W-1:0] V_IDLE = 7'b0100001;
   localparam logic [W-1:0] V_IPG  = 7'b1000001;
   localparam logic [W-1:0] V_ERR  = 7'b1000100;
   localparam logic [W-1:0] V_EXT  = 7'b1000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       half_duplex = 1'b0;
   logic       complete, extend, extenderror, zero, one, busy;
   logic [2:0] dbg_state;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];
   logic [7:0]   frm[$];

   pls_tx_sequencer_if mac_if ();

   pls_tx_sequencer #(
      .SLOT_BITS(SLOT_BITS), .IPG_BITS(IPG_BITS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mac(mac_if),
      .half_duplex(half_duplex),
      .pls_data_request_complete(complete),
      .pls_data_request_extend(extend),
      .pls_data_request_extenderror(extenderror),
      .pls_data_request_zero(zero),
      .pls_data_request_one(one),
      .busy(busy),
      .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [W-1:0] obs();
      return {busy, mac_if.mac_ready, one, zero, extenderror, extend, complete};
   endfunction

   task automatic drive_idle();
      mac_if.mac_data  = '0;
      mac_if.mac_valid = 1'b0;
      mac_if.mac_last  = 1'b0;
      mac_if.mac_abort = 1'b0;
   endtask

   // Reference: the whole frame as a list of per-cycle symbols, from
   // the frame contents, duplex mode and how it ends.
   task automatic build_model(input bit hd, input int abort_at, input bit underrun);
      int   n, nb, k, b;
      logic v, r;
      n  = frm.size();
      nb = (abort_at > 0) ? abort_at : 8 * n;
      exp_q.delete();
      for (int i = 0; i < nb; i++) begin
         k = i / 8;
         b = i % 8;
         v = frm[k][b];
         r = (b == 7) && !((k == n - 1) && !underrun);
         exp_q.push_back({1'b1, r, v, ~v, 3'b000});
      end
      if (abort_at > 0 || underrun) begin
         for (int i = 0; i < 8; i++) exp_q.push_back(V_ERR);
      end else if (hd && nb < SLOT_BITS) begin
         for (int i = nb; i < SLOT_BITS; i++) exp_q.push_back(V_EXT);
      end
      for (int i = 0; i < IPG_BITS; i++) exp_q.push_back(V_IPG);
      exp_q.push_back(V_IDLE);
   endtask

   // Drives frm on its natural schedule (byte k offered when bit 7 of
   // byte k-1 is on the wire) and checks every cycle until idle.
   task automatic run_frame(input string name, input bit hd, input int abort_at,
                            input bit underrun, input bit abort_hold);
      logic [W-1:0] prev, got, exp;
      int n;
      n = frm.size();
      build_model(hd, abort_at, underrun);
      prev = V_IDLE;
      for (int c = 0; exp_q.size() > 0; c++) begin
         mac_if.mac_data  = 8'($urandom);
         mac_if.mac_last  = 1'($urandom);
         mac_if.mac_valid = 1'b0;
         mac_if.mac_abort = 1'b0;
         half_duplex      = 1'($urandom);
         if (c == 0) begin
            mac_if.mac_valid = 1'b1;
            mac_if.mac_data  = frm[0];
            mac_if.mac_last  = (n == 1) && !underrun;
            half_duplex      = hd;
         end else if (prev[4] | prev[3]) begin
            if (abort_at > 0 && c == abort_at) begin
               mac_if.mac_abort = 1'b1;
            end else if (c % 8 == 0 && c / 8 < n) begin
               mac_if.mac_valid = 1'b1;
               mac_if.mac_data  = frm[c / 8];
               mac_if.mac_last  = (c / 8 == n - 1) && !underrun;
            end else if (!prev[5]) begin
               mac_if.mac_valid = 1'($urandom);
            end
         end else if (!prev[5]) begin
            mac_if.mac_valid = 1'($urandom);
            mac_if.mac_abort = abort_hold ? 1'b1 : 1'($urandom);
         end
         @(posedge clk);
         #1;
         got = obs();
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c + 1, got, exp);
         end
         prev = exp;
      end
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs(), V_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_idle %0d: got %b expected %b", i, obs(), V_IDLE);
         end
      end
   endtask

   task automatic test_full_duplex();
      frm = '{8'hA5, 8'h3C};
      run_frame("fd_a5_3c", 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_half_single();
      frm = '{8'hFF};
      run_frame("hd_ff_extend_abort", 1'b1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_half_slot();
      frm.delete();
      for (int i = 0; i < 8; i++) frm.push_back(8'($urandom));
      run_frame("hd_slot_8byte", 1'b1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_underrun();
      frm = '{8'h5A};
      run_frame("underrun", 1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic test_abort();
      frm = '{8'hC3, 8'h81};
      run_frame("abort_bit3", 1'b1, 4, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      mac_if.mac_valid = 1'b1;
      mac_if.mac_data  = 8'h96;
      mac_if.mac_last  = 1'b0;
      half_duplex      = 1'b1;
      @(posedge clk);
      #1;
      drive_idle();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL reset_mid_async: got %b expected %b", obs(), V_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL reset_mid_idle: got %b expected %b", obs(), V_IDLE);
      end
      frm = '{8'h12, 8'h34};
      run_frame("after_reset", 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int n, ab;
      bit hd, ur;
      for (int f = 0; f < 25; f++) begin
         n = $urandom_range(1, 10);
         frm.delete();
         for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
         hd = 1'($urandom);
         ab = 0;
         ur = 1'b0;
         case ($urandom_range(0, 3))
            0: ab = $urandom_range(1, 8 * n);
            1: ur = 1'b1;
            default: ;
         endcase
         run_frame($sformatf("rand_%0d", f), hd, ab, ur, 1'b0);
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_full_duplex();
      test_half_single();
      test_half_slot();
      test_underrun();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
